// File: rtl/alu_pkg.sv
// Shared types and sizing helpers for the chunked adder-subtractor.
package alu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Number of RUN cycles per operation.
  function automatic int nchunk(input int width, input int chunk);
    return width / chunk;
  endfunction

  // Chunk index width; at least one bit even when there is a single chunk.
  function automatic int idx_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/chunked_add_sub_if.sv
// Operand/result handshake bundle. The master is the operand source and
// result consumer; the slave is the adder-subtractor.
interface chunked_add_sub_if #(parameter int WIDTH = 16);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             sub;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] s;
  logic             cout;
  logic             overflow;
  logic             zero;
  logic             negative;
  logic             busy;

  modport master (
    output in_valid, a, b, sub, cin, out_ready,
    input  in_ready, out_valid, s, cout, overflow, zero, negative, busy
  );

  modport slave (
    input  in_valid, a, b, sub, cin, out_ready,
    output in_ready, out_valid, s, cout, overflow, zero, negative, busy
  );
endinterface

// File: rtl/chunked_add_sub_add_chunk.sv
// Combinational CHUNK-bit ripple adder. Also exposes the carry into its top
// bit so the parent can form signed overflow on the last chunk.
module add_chunk #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] i_a,
  input  logic [CHUNK-1:0] i_b,
  input  logic             i_cin,
  output logic [CHUNK-1:0] o_sum,
  output logic             o_cout,
  output logic             o_c_msb
);
  logic [CHUNK:0] w_full;

  assign w_full  = {1'b0, i_a} + {1'b0, i_b} + {{CHUNK{1'b0}}, i_cin};
  assign o_sum   = w_full[CHUNK-1:0];
  assign o_cout  = w_full[CHUNK];
  // sum = a ^ b ^ carry_in per bit, so the carry into the top bit falls out
  // of the top bit of sum ^ a ^ b (reduces to cin when CHUNK is 1).
  assign o_c_msb = w_full[CHUNK-1] ^ i_a[CHUNK-1] ^ i_b[CHUNK-1];
endmodule

// File: rtl/chunked_add_sub.sv
// Multi-cycle adder-subtractor: WIDTH bits processed CHUNK bits per cycle,
// carry rippled through a register, valid/ready on both sides.
module chunked_add_sub
  import alu_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input logic              clk,
  input logic              rst_n,
  chunked_add_sub_if.slave bus
);
  localparam int NCHUNK = nchunk(WIDTH, CHUNK);
  localparam int IW     = idx_w(NCHUNK);
  localparam logic [IW-1:0] LAST = IW'(NCHUNK - 1);

  if (WIDTH < 2 || CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_params
    $error("chunked_add_sub: WIDTH must be >= 2 and a multiple of CHUNK");
  end

  state_e           r_state;
  logic [IW-1:0]    r_idx;
  logic             r_carry;
  logic             r_cout;
  logic             r_ovf;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_s;

  logic [CHUNK-1:0] w_sum;
  logic             w_cout;
  logic             w_c_msb;
  int unsigned      w_base;

  assign w_base = int'(r_idx) * CHUNK;

  add_chunk #(.CHUNK(CHUNK)) u_chunk (
    .i_a     (r_a[w_base +: CHUNK]),
    .i_b     (r_b[w_base +: CHUNK]),
    .i_cin   (r_carry),
    .o_sum   (w_sum),
    .o_cout  (w_cout),
    .o_c_msb (w_c_msb)
  );

  // Control FSM plus datapath registers. Subtraction is folded in at accept
  // time (invert B, invert borrow-in) so RUN is a pure add.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_idx   <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
      r_a     <= '0;
      r_b     <= '0;
      r_s     <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.in_valid) begin
            r_a     <= bus.a;
            r_b     <= bus.sub ? ~bus.b : bus.b;
            r_carry <= bus.sub ^ bus.cin;
            r_idx   <= '0;
            r_state <= RUN;
          end
        end
        RUN: begin
          r_s[w_base +: CHUNK] <= w_sum;
          r_carry              <= w_cout;
          if (r_idx == LAST) begin
            r_idx   <= '0;
            r_cout  <= w_cout;
            r_ovf   <= w_cout ^ w_c_msb;
            r_state <= DONE;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        DONE: begin
          if (bus.out_ready) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (r_state == IDLE);
  assign bus.out_valid = (r_state == DONE);
  assign bus.busy      = (r_state != IDLE);
  assign bus.s         = r_s;
  assign bus.cout      = r_cout;
  assign bus.overflow  = r_ovf;
  assign bus.zero      = (r_s == '0);
  assign bus.negative  = r_s[WIDTH-1];
endmodule

// File: tb/tb_chunked_add_sub.sv
// Bench for chunked_add_sub: directed corner cases on a 16/4 instance, then a
// 32/8 instance with a randomized sweep against an integer reference model.
module tb_chunked_add_sub;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  chunked_add_sub_if #(.WIDTH(16)) if16 ();
  chunked_add_sub_if #(.WIDTH(32)) if32 ();

  chunked_add_sub #(.WIDTH(16), .CHUNK(4)) dut16 (.clk(clk), .rst_n(rst_n), .bus(if16.slave));
  chunked_add_sub #(.WIDTH(32), .CHUNK(8)) dut32 (.clk(clk), .rst_n(rst_n), .bus(if32.slave));

  typedef struct packed {
    logic        out_valid;
    logic        in_ready;
    logic        busy;
    logic        cout;
    logic        ovf;
    logic        zero;
    logic        neg;
    logic [63:0] s;
  } obs_t;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic obs_t peek(input bit big);
    obs_t o;
    if (big) begin
      o = '{if32.out_valid, if32.in_ready, if32.busy, if32.cout, if32.overflow,
            if32.zero, if32.negative, 64'(if32.s)};
    end else begin
      o = '{if16.out_valid, if16.in_ready, if16.busy, if16.cout, if16.overflow,
            if16.zero, if16.negative, 64'(if16.s)};
    end
    return o;
  endfunction

  task automatic drv(input bit big, input logic v, input logic [63:0] a, input logic [63:0] b,
                     input logic sub, input logic cin);
    if (big) begin
      if32.in_valid = v; if32.a = a[31:0]; if32.b = b[31:0]; if32.sub = sub; if32.cin = cin;
    end else begin
      if16.in_valid = v; if16.a = a[15:0]; if16.b = b[15:0]; if16.sub = sub; if16.cin = cin;
    end
  endtask

  task automatic set_ordy(input bit big, input logic v);
    if (big) if32.out_ready = v;
    else     if16.out_ready = v;
  endtask

  // Reference: plain integer arithmetic, unsigned and signed views separately.
  function automatic void model(input int w, input logic [63:0] a, input logic [63:0] b,
                                input bit sub, input bit cin,
                                output logic [63:0] s, output bit c, output bit v);
    longint m  = longint'(1) <<< w;
    longint ua = longint'(a);
    longint ub = longint'(b);
    longint ci = cin ? 1 : 0;
    longint sa = a[w-1] ? ua - m : ua;
    longint sb = b[w-1] ? ub - m : ub;
    longint ur, sr;
    if (!sub) begin
      ur = ua + ub + ci; sr = sa + sb + ci; c = (ur >= m);
    end else begin
      ur = ua - ub - ci; sr = sa - sb - ci; c = (ur >= 0);
    end
    v = (sr >= m / 2) || (sr < -(m / 2));
    s = 64'(ur) & 64'(m - 1);
  endfunction

  // One full transaction: accept, latency, result, optional stall, release.
  task automatic do_op(input bit big, input logic [63:0] a, input logic [63:0] b,
                       input bit sub, input bit cin, input int stall, input bit pulse,
                       input string tag);
    int w = big ? 32 : 16;
    logic [63:0] es;
    bit ec, eo;
    obs_t o, o0;
    int n, lat;
    model(w, a, b, sub, cin, es, ec, eo);
    n = 0;
    o = peek(big);
    while (!o.in_ready && n < 50) begin @(posedge clk); #1; o = peek(big); n++; end
    check({tag, " in_ready"}, 64'(o.in_ready), 64'd1);
    drv(big, 1'b1, a, b, sub, cin);
    @(posedge clk); #1;
    drv(big, 1'b0, 64'd0, 64'd0, 1'b0, 1'b0);
    lat = 0;
    o = peek(big);
    while (!o.out_valid && lat < 20) begin
      if (pulse && lat == 1) drv(big, 1'b1, ~a, ~b, ~sub, ~cin);
      else                   drv(big, 1'b0, 64'd0, 64'd0, 1'b0, 1'b0);
      @(posedge clk); #1;
      lat++;
      o = peek(big);
    end
    drv(big, 1'b0, 64'd0, 64'd0, 1'b0, 1'b0);
    check({tag, " latency"}, 64'(lat), 64'd4);
    check({tag, " S"}, o.s, es);
    check({tag, " cout"}, 64'(o.cout), 64'(ec));
    check({tag, " ovf"}, 64'(o.ovf), 64'(eo));
    check({tag, " zero"}, 64'(o.zero), 64'(es == 64'd0));
    check({tag, " neg"}, 64'(o.neg), 64'(es[w-1]));
    check({tag, " rdy_in_done"}, 64'(o.in_ready), 64'd0);
    o0 = o;
    for (int i = 0; i < stall; i++) begin
      @(posedge clk); #1;
      o = peek(big);
      check({tag, " hold S"}, o.s, o0.s);
      check({tag, " hold flags"}, 64'(o[70:64]), 64'(o0[70:64]));
    end
    set_ordy(big, 1'b1);
    @(posedge clk); #1;
    set_ordy(big, 1'b0);
    o = peek(big);
    check({tag, " valid_drop"}, 64'(o.out_valid), 64'd0);
    check({tag, " ready_back"}, 64'(o.in_ready), 64'd1);
  endtask

  initial begin
    obs_t o;
    logic [63:0] ra, rb;
    drv(1'b0, 1'b0, 64'd0, 64'd0, 1'b0, 1'b0);
    drv(1'b1, 1'b0, 64'd0, 64'd0, 1'b0, 1'b0);
    set_ordy(1'b0, 1'b0);
    set_ordy(1'b1, 1'b0);

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    o = peek(1'b0);
    check("rst ready", 64'(o.in_ready), 64'd1);
    check("rst valid", 64'(o.out_valid), 64'd0);
    check("rst busy", 64'(o.busy), 64'd0);
    check("rst S", o.s, 64'd0);
    check("rst flags", {62'd0, o.cout, o.ovf}, 64'd0);
    check("rst zero", 64'(o.zero), 64'd1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed 16-bit cases
    do_op(1'b0, 64'h7FFF, 64'h0001, 1'b0, 1'b0, 0, 1'b0, "max_pos_inc");
    do_op(1'b0, 64'hFFFF, 64'h0001, 1'b0, 1'b0, 0, 1'b0, "wrap_zero");
    do_op(1'b0, 64'h0005, 64'h0007, 1'b1, 1'b0, 0, 1'b0, "sub_neg");
    do_op(1'b0, 64'h8000, 64'h0001, 1'b1, 1'b0, 0, 1'b0, "sub_ovf");
    do_op(1'b0, 64'h1234, 64'h1111, 1'b0, 1'b1, 3, 1'b1, "backpressure");
    do_op(1'b0, 64'h0000, 64'h0000, 1'b1, 1'b1, 0, 1'b0, "borrow_in");

    // Reset during RUN
    drv(1'b0, 1'b1, 64'h1234, 64'h4321, 1'b0, 1'b0);
    @(posedge clk); #1;
    drv(1'b0, 1'b0, 64'd0, 64'd0, 1'b0, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    o = peek(1'b0);
    check("midrun valid", 64'(o.out_valid), 64'd0);
    check("midrun S", o.s, 64'd0);
    check("midrun ready", 64'(o.in_ready), 64'd1);
    check("midrun busy", 64'(o.busy), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    do_op(1'b0, 64'h0001, 64'h0001, 1'b0, 1'b0, 0, 1'b0, "after_rst");

    // 32-bit instance
    do_op(1'b1, 64'hFFFF_FFFF, 64'h0, 1'b0, 1'b1, 0, 1'b0, "w32_wrap");
    for (int i = 0; i < 1000; i++) begin
      ra = 64'($urandom);
      rb = 64'($urandom);
      case ($urandom_range(0, 7))
        0: rb = ra;
        1: ra = 64'hFFFF_FFFF;
        2: ra = 64'h8000_0000;
        3: rb = 64'h7FFF_FFFF;
        default: ;
      endcase
      do_op(1'b1, ra, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)), "rand32");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/chunked_add_sub.md
# chunked_add_sub

Multi-cycle, parametrised signed/unsigned adder-subtractor for the ALU. It processes a WIDTH-bit operation CHUNK bits per clock, rippling the carry through a register between chunks, and raises carry, overflow, zero and negative flags. Operands enter and results leave on independent valid/ready handshakes, so the block can sit between the decode stage and the writeback path with backpressure on either side.

## Interface
- WIDTH, 16: operand/result width in bits; must be at least 2.
- CHUNK, 4: bits processed per cycle; must divide WIDTH.
- NCHUNK (derived, WIDTH/CHUNK): cycles per operation.

Ports:
- Clk  input  1  system clock, rising edge.
- Rst_n  input  1  reset, asynchronous, active-low.
- In_valid  input  1  operand presented.
- In_ready  output  1  block can accept operands.
- A  input  WIDTH  operand A.
- B  input  WIDTH  operand B.
- Sub  input  1  0 selects A+B+Cin; 1 selects A−B−Cin.
- Cin  input  1  carry-in (add) or borrow-in (sub).
- Out_valid  output  1  result and flags valid.
- Out_ready  input  1  consumer takes the result.
- S  output  WIDTH  result.
- Cout  output  1  raw carry out of the MSB (for subtraction, 1 means no borrow).
- Overflow  output  1  signed overflow.
- Zero  output  1  S equals 0.
- Negative  output  1  S[WIDTH-1].
- Busy  output  1  state is not IDLE.

## Operation
- States: IDLE, RUN, DONE.
- **IDLE:** In_ready=1. When In_valid&&In_ready, capture A, B_eff and the initial carry, set idx=0, and go to RUN.
  - Add: B_eff=B, c0=Cin.
  - Sub: B_eff=~B, c0=~Cin.
- **RUN:** In_ready=0. Each cycle, add chunk idx of A and B_eff plus carry_reg.
  - Write the sum into S[idx*CHUNK +: CHUNK].
  - Update carry_reg with the chunk carry-out, then increment idx.
  - On the last chunk (idx==NCHUNK−1):
    - Cout = chunk carry-out.
    - Overflow = carry into bit WIDTH−1 XOR carry out of bit WIDTH−1.
    - Go to DONE.
- **DONE:** Out_valid=1. S and all flags are held stable and In_ready=0 until Out_ready=1.
  - On Out_valid&&Out_ready, go to IDLE.
  - No bypass: a new operand is accepted at the earliest one cycle after the result is taken.
- Zero and Negative are combinational on the registered S. They are meaningful only while Out_valid=1.
- Arithmetic is modulo 2^WIDTH, and a single datapath serves both signed and unsigned use. Cout is the unsigned flag; Overflow is the signed flag.
- In_valid while In_ready=0 is ignored; the source must hold its operands.
- Out_ready outside DONE has no effect.

## Timing
- Reset values: state=IDLE, In_ready=1, Out_valid=0, Busy=0, S=0, Cout=0, Overflow=0, idx=0, carry_reg=0.
  - Zero is therefore 1 during reset, but it is meaningful only while Out_valid=1.
- Latency: if operands are accepted on edge k, Out_valid rises after edge k+NCHUNK.
- Throughput: at best one operation per NCHUNK+2 cycles (accept cycle, NCHUNK RUN cycles, one DONE cycle).
- Reset asserted mid-RUN or in DONE:
  - The operation is aborted immediately; no result is produced.
  - All outputs return to their reset values asynchronously.
- Deassertion of Rst_n is assumed synchronised upstream.
- With CHUNK=WIDTH, NCHUNK=1: RUN lasts exactly one cycle and the block still goes through DONE.

## Structure
- Package alu_pkg holds:
  - the state enum (IDLE, RUN, DONE);
  - localparam helpers for NCHUNK and the idx width, clog2(NCHUNK) with a minimum of 1.
- One sub-module, add_chunk: combinational CHUNK-bit ripple adder.
  - Inputs: a, b, cin.
  - Outputs: sum, cout, and c_msb (the carry into its top bit, used for Overflow).
- Top level: FSM, idx counter, carry register, operand registers, S assembly, handshake logic.

## Test plan
Scenarios 1–4 use WIDTH=16, CHUNK=4.

1. 0x7FFF + 0x0001, Sub=0, Cin=0 → S=0x8000, Cout=0, Overflow=1, Negative=1, Zero=0. Out_valid must rise exactly 4 cycles after the accept edge.
2. 0xFFFF + 0x0001, Sub=0, Cin=0 → S=0x0000, Cout=1, Overflow=0, Zero=1.
3. Subtractions with Cin=0:
   - 0x0005 − 0x0007 → S=0xFFFE, Cout=0, Overflow=0, Negative=1.
   - 0x8000 − 0x0001 → S=0x7FFF, Cout=1, Overflow=1.
4. Backpressure: 0x1234 + 0x1111 with Cin=1 (result 0x2346), Out_ready held low for 3 DONE cycles.
   - S, flags and Out_valid stay stable, and In_ready stays 0.
   - Raise Out_ready → IDLE on the next edge and In_ready=1.
   - A second In_valid pulse during RUN is ignored.
5. Reset mid-RUN: drop Rst_n after the 2nd RUN cycle → Out_valid=0, S=0, In_ready=1 immediately. After release, a fresh 0x0001 + 0x0001 yields S=0x0002.
6. WIDTH=32, CHUNK=8: 0xFFFFFFFF + 0x00000000 with Cin=1 → S=0x00000000, Cout=1, Zero=1, latency 4. Then a random sweep of 1000 operations against a reference model.
